// File: rtl/period_capture.sv
// Input-capture block: measures clk cycles between successive rising
// edges of pulse_in and reports them as an N-bit period with a one-cycle strobe.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   enable       measurement enable; low forces IDLE
//   pulse_in     pulse to measure (already synchronous to clk)
//   period       last measured edge-to-edge interval, in clk cycles
//   period_valid one-cycle strobe; period/overflow updated this cycle
//   overflow     reported period saturated at 2^N-1
module period_capture #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         pulse_in,
  output logic [N-1:0] period,
  output logic         period_valid,
  output logic         overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [N-1:0] CNT_MAX = '1;
  localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

  state_t       state;
  state_t       state_n;
  logic [N-1:0] cnt;
  logic [N-1:0] cnt_n;
  logic         sat;
  logic         sat_n;
  logic         pulse_d;
  logic         edge_det;
  logic         upd;

  assign edge_det = pulse_in & ~pulse_d;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sat_n   = sat;
    upd     = 1'b0;
    if (!enable) begin
      // Disable discards any in-flight measurement, even on an edge.
      state_n = IDLE;
      cnt_n   = '0;
      sat_n   = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_n = ARMED;
          cnt_n   = '0;
          sat_n   = 1'b0;
        end
        ARMED: begin
          if (edge_det) begin
            state_n = MEASURE;
            cnt_n   = CNT_ONE;
            sat_n   = 1'b0;
          end
        end
        MEASURE: begin
          if (edge_det) begin
            // Report and restart on the same edge: no dead cycle.
            upd   = 1'b1;
            cnt_n = CNT_ONE;
            sat_n = 1'b0;
          end else if (cnt != CNT_MAX) begin
            cnt_n = cnt + CNT_ONE;
          end else begin
            sat_n = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
          sat_n   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      sat          <= 1'b0;
      pulse_d      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sat          <= sat_n;
      pulse_d      <= pulse_in;
      period_valid <= upd;
      if (upd) begin
        period   <= cnt;
        overflow <= sat;
      end
    end
  end

endmodule

// File: tb/tb_period_capture.sv
// Bench for period_capture: N=16 and N=8 instances share one stimulus;
// expected strobes are queued when edges are driven and checked on output.
module tb_period_capture;

  typedef struct {
    int          cyc;
    logic [15:0] per;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        pulse_in = 1'b0;
  logic [15:0] per16;
  logic        vld16;
  logic        ovf16;
  logic [7:0]  per8;
  logic        vld8;
  logic        ovf8;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   last_s = -1;
  int   last16 = 0;
  int   last8 = 0;
  exp_t q16[$];
  exp_t q8[$];

  period_capture #(.N(16)) dut16 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .period       (per16),
    .period_valid (vld16),
    .overflow     (ovf16)
  );

  period_capture #(.N(8)) dut8 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .period       (per8),
    .period_valid (vld8),
    .overflow     (ovf8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edge sampled at the next posedge; its strobe shows in that cycle.
  task automatic note_edge();
    int s;
    int d;
    exp_t e;
    s = cyc + 1;
    if (last_s >= 0) begin
      d = s - last_s;
      e.cyc = s;
      e.per = (d > 65535) ? 16'hffff : d[15:0];
      e.ovf = (d > 65535);
      q16.push_back(e);
      last16 = e.per;
      e.per = (d > 255) ? 16'd255 : d[15:0];
      e.ovf = (d > 255);
      q8.push_back(e);
      last8 = e.per;
    end
    last_s = s;
  endtask

  task automatic set_pulse(input logic v);
    if (v && !pulse_in && enable && !reset) note_edge();
    pulse_in = v;
  endtask

  task automatic set_en(input logic v);
    if (!v) last_s = -1;
    enable = v;
  endtask

  // One-cycle pulse; the following rise lands n cycles after this one.
  task automatic pulse_gap(input int n);
    set_pulse(1'b1);
    tick();
    set_pulse(1'b0);
    repeat (n - 1) tick();
  endtask

  task automatic mon16();
    exp_t e;
    if (vld16 === 1'b1) begin
      chk("strobe16_expected", q16.size() > 0, 1);
      if (q16.size() > 0) begin
        e = q16.pop_front();
        chk("strobe16_cycle", cyc, e.cyc);
        chk("period16", per16, e.per);
        chk("overflow16", ovf16, e.ovf);
      end
    end else if (q16.size() > 0 && q16[0].cyc <= cyc) begin
      e = q16.pop_front();
      chk("strobe16_missing", vld16, 1);
    end
  endtask

  task automatic mon8();
    exp_t e;
    if (vld8 === 1'b1) begin
      chk("strobe8_expected", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("strobe8_cycle", cyc, e.cyc);
        chk("period8", per8, e.per);
        chk("overflow8", ovf8, e.ovf);
      end
    end else if (q8.size() > 0 && q8[0].cyc <= cyc) begin
      e = q8.pop_front();
      chk("strobe8_missing", vld8, 1);
    end
  endtask

  always @(negedge clk) begin
    mon16();
    mon8();
  end

  initial begin
    // 1. Reset with pulse_in toggling
    reset = 1'b1;
    set_pulse(1'b1);
    tick();
    set_pulse(1'b0);
    tick();
    set_pulse(1'b1);
    chk("rst_period16", per16, 0);
    chk("rst_valid16", vld16, 0);
    chk("rst_ovf16", ovf16, 0);
    chk("rst_period8", per8, 0);
    chk("rst_valid8", vld8, 0);
    chk("rst_ovf8", ovf8, 0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      set_pulse(i[2]);
      tick();
    end
    set_pulse(1'b0);
    chk("idle_period16", per16, 0);
    chk("idle_valid16", vld16, 0);

    // 2. Timer loopback, 257-cycle gaps
    set_en(1'b1);
    repeat (5) tick();
    for (int i = 0; i < 5; i++) pulse_gap(257);

    // 3. Rate change to 50000, then back
    pulse_gap(50000);
    pulse_gap(257);

    // 4. Minimum interval and level input
    pulse_gap(300);
    pulse_gap(2);
    pulse_gap(2);
    set_pulse(1'b1);
    repeat (40) tick();
    set_pulse(1'b0);
    repeat (60) tick();

    // 5. Overflow boundaries for N=8
    pulse_gap(300);
    pulse_gap(100);
    pulse_gap(255);
    pulse_gap(256);
    pulse_gap(20);

    // 6a. Disable mid-gap, pulse high at re-enable
    repeat (2) tick();
    chk("hold16_pre", per16, last16);
    chk("hold8_pre", per8, last8);
    set_en(1'b0);
    repeat (5) tick();
    set_pulse(1'b1);
    repeat (5) tick();
    chk("hold16_idle", per16, last16);
    chk("hold8_idle", per8, last8);
    set_en(1'b1);
    repeat (10) tick();
    set_pulse(1'b0);
    repeat (5) tick();
    chk("hold16_rearm", per16, last16);
    pulse_gap(70);
    pulse_gap(33);

    // Enable falls on the same cycle as an edge
    repeat (20) tick();
    set_en(1'b0);
    set_pulse(1'b1);
    tick();
    set_pulse(1'b0);
    repeat (3) tick();
    set_en(1'b1);
    repeat (4) tick();
    pulse_gap(40);
    pulse_gap(9);

    // 6b. Reset mid-gap, coinciding with an edge
    repeat (15) tick();
    reset = 1'b1;
    last_s = -1;
    set_pulse(1'b1);
    tick();
    reset = 1'b0;
    chk("rst2_period16", per16, 0);
    chk("rst2_ovf16", ovf16, 0);
    chk("rst2_period8", per8, 0);
    chk("rst2_valid8", vld8, 0);
    last16 = 0;
    last8 = 0;
    repeat (6) tick();
    set_pulse(1'b0);
    repeat (4) tick();
    chk("rst2_hold16", per16, 0);
    pulse_gap(123);
    pulse_gap(7);
    repeat (10) tick();

    chk("q16_drained", q16.size(), 0);
    chk("q8_drained", q8.size(), 0);
    chk("final_period16", per16, 123);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
